// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the regfile/datapath sequencer.
// State encoding, opcode/op values and instruction field positions.
package regfile_seq_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WIMM,
    S_GETA,
    S_GETB,
    S_ALU,
    S_WB
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVIMM = 2'b10;
  localparam logic [1:0] OP_MOVREG = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_CMP    = 2'b01;
  localparam logic [1:0] OP_AND    = 2'b10;
  localparam logic [1:0] OP_MVN    = 2'b11;

  localparam int OPC_LO = 13;
  localparam int OP_LO  = 11;
  localparam int RN_LO  = 8;
  localparam int RD_LO  = 5;
  localparam int SH_LO  = 3;
  localparam int RM_LO  = 0;
  localparam int IMM_LO = 0;

  localparam logic VSEL_C   = 1'b0;
  localparam logic VSEL_IMM = 1'b1;

endpackage

// File: rtl/regfile_seq_ctrl.sv
// Moore sequencer: latches one instruction, then steps the regfile
// and datapath strobes through read, ALU and write-back cycles.
module regfile_seq_ctrl
  import regfile_seq_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s,
  input  logic [15:0]   instr,
  output logic          w,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic          vsel,
  output logic [1:0]    shift,
  output logic [1:0]    aluop,
  output logic [DW-1:0] sximm8,
  output logic          err
);

  state_t      state;
  logic [15:0] ir;

  logic [2:0] opc;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [2:0] rm;
  logic [1:0] sh;
  logic [7:0] imm8;

  assign opc  = ir[OPC_LO +: 3];
  assign op   = ir[OP_LO +: 2];
  assign rn   = ir[RN_LO +: 3];
  assign rd   = ir[RD_LO +: 3];
  assign rm   = ir[RM_LO +: 3];
  assign sh   = ir[SH_LO +: 2];
  assign imm8 = ir[IMM_LO +: 8];

  logic is_movi;
  logic is_movr;
  logic is_alu;
  logic is_cmp;
  logic is_mvn;
  logic is_two;

  assign is_movi = (opc == OPC_MOV) && (op == OP_MOVIMM);
  assign is_movr = (opc == OPC_MOV) && (op == OP_MOVREG);
  assign is_alu  = (opc == OPC_ALU);
  assign is_cmp  = is_alu && (op == OP_CMP);
  assign is_mvn  = is_alu && (op == OP_MVN);
  // Two-operand ops read Rn first; the rest go straight to Rm.
  assign is_two  = is_alu && (op != OP_MVN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_WAIT;
      ir    <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        S_WAIT: begin
          if (s) begin
            ir    <= instr;
            err   <= 1'b0;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          unique case (1'b1)
            is_movi:          state <= S_WIMM;
            is_movr, is_mvn:  state <= S_GETB;
            is_two:           state <= S_GETA;
            default: begin
              state <= S_WAIT;
              err   <= 1'b1;
            end
          endcase
        end
        S_WIMM: state <= S_WAIT;
        S_GETA: state <= S_GETB;
        S_GETB: state <= S_ALU;
        S_ALU:  state <= is_cmp ? S_WAIT : S_WB;
        S_WB:   state <= S_WAIT;
        default: state <= S_WAIT;
      endcase
    end
  end

  assign bsel   = 1'b0;
  assign shift  = is_movi ? 2'b00 : sh;
  assign aluop  = is_movr ? 2'b00 : op;
  assign sximm8 = {{(DW-8){imm8[7]}}, imm8};

  always_comb begin
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    vsel     = VSEL_C;
    unique case (state)
      S_WAIT: w = 1'b1;
      S_WIMM: begin
        writenum = RW'(rn);
        vsel     = VSEL_IMM;
        write    = 1'b1;
      end
      S_GETA: begin
        readnum = RW'(rn);
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = RW'(rm);
        loadb   = 1'b1;
      end
      S_ALU: begin
        asel  = is_movr;
        loadc = !is_cmp;
        loads = is_cmp;
      end
      S_WB: begin
        writenum = RW'(rd);
        vsel     = VSEL_C;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Scoreboard bench for regfile_seq_ctrl: directed instructions push
// hand-computed per-cycle output snapshots; a monitor pops and compares.
module tb_regfile_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s = 1'b0;
  logic [15:0] instr = '0;

  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic        vsel;
  logic [1:0]  shift;
  logic [1:0]  aluop;
  logic [15:0] sximm8;
  logic        err;

  regfile_seq_ctrl #(.DW(16), .RW(3)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .instr(instr),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift),
    .aluop(aluop), .sximm8(sximm8), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [2:0]  rn;
    logic [2:0]  wn;
    logic        wr;
    logic        la;
    logic        lb;
    logic        lc;
    logic        ls;
    logic        as;
    logic        bs;
    logic        vs;
    logic [1:0]  sh;
    logic [1:0]  op;
    logic [15:0] imm;
    logic        er;
  } snap_t;

  snap_t sb[$];
  int total = 0;
  int bad = 0;

  logic [1:0]  e_sh;
  logic [1:0]  e_op;
  logic [15:0] e_imm;

  function automatic snap_t dut_snap();
    snap_t x;
    x.w = w;     x.rn = readnum; x.wn = writenum; x.wr = write;
    x.la = loada; x.lb = loadb;  x.lc = loadc;    x.ls = loads;
    x.as = asel;  x.bs = bsel;   x.vs = vsel;     x.sh = shift;
    x.op = aluop; x.imm = sximm8; x.er = err;
    return x;
  endfunction

  task automatic chk(string name, snap_t act, snap_t exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp_v);
    end
  endtask

  task automatic chkb(string name, logic act, logic exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp_v);
    end
  endtask

  task automatic exp(logic w_, logic [2:0] rn, logic [2:0] wn,
                     logic wr, logic la, logic lb, logic lc,
                     logic ls, logic as, logic vs, logic er);
    snap_t x;
    x.w = w_; x.rn = rn; x.wn = wn; x.wr = wr;
    x.la = la; x.lb = lb; x.lc = lc; x.ls = ls;
    x.as = as; x.bs = 1'b0; x.vs = vs;
    x.sh = e_sh; x.op = e_op; x.imm = e_imm; x.er = er;
    sb.push_back(x);
  endtask

  task automatic issue(logic [15:0] i, bit keep);
    int n;
    n = 0;
    @(negedge clk);
    while (!w && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!w) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: w=%b want 1 for instr %h", w, i);
    end
    s = 1'b1;
    instr = i;
    @(posedge clk);
    #1;
    if (!keep) s = 1'b0;
  endtask

  initial begin
    bit pb;
    bit busy;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pb = 1'b0;
      end else begin
        busy = !w;
        if (busy || pb) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected: got %h want none", dut_snap());
          end else begin
            chk("seq", dut_snap(), sb.pop_front());
          end
        end
        pb = busy;
      end
    end
  end

  initial begin
    snap_t rst_exp;
    int n;
    int wcnt;
    rst_exp = '0;
    rst_exp.w = 1'b1;

    #1;
    chk("reset", dut_snap(), rst_exp);
    @(negedge clk);
    rst_n = 1'b1;

    // MOV R3,#0x85
    e_sh = 2'b00; e_op = 2'b10; e_imm = 16'hFF85;
    issue(16'hD385, 1'b0);
    exp(0,0,0,0,0,0,0,0,0,0,0);
    exp(0,0,3,1,0,0,0,0,0,1,0);
    exp(1,0,0,0,0,0,0,0,0,0,0);

    // ADD R2,R1,R0
    e_sh = 2'b00; e_op = 2'b00; e_imm = 16'h0040;
    issue(16'hA140, 1'b0);
    exp(0,0,0,0,0,0,0,0,0,0,0);
    exp(0,1,0,0,1,0,0,0,0,0,0);
    exp(0,0,0,0,0,1,0,0,0,0,0);
    exp(0,0,0,0,0,0,1,0,0,0,0);
    exp(0,0,2,1,0,0,0,0,0,0,0);
    exp(1,0,0,0,0,0,0,0,0,0,0);

    // CMP R1,R0
    e_sh = 2'b00; e_op = 2'b01; e_imm = 16'h0000;
    issue(16'hA900, 1'b0);
    exp(0,0,0,0,0,0,0,0,0,0,0);
    exp(0,1,0,0,1,0,0,0,0,0,0);
    exp(0,0,0,0,0,1,0,0,0,0,0);
    exp(0,0,0,0,0,0,0,1,0,0,0);
    exp(1,0,0,0,0,0,0,0,0,0,0);

    // MOV R5,R7 LSL with s raised while busy
    e_sh = 2'b01; e_op = 2'b00; e_imm = 16'hFFAF;
    issue(16'hC0AF, 1'b0);
    exp(0,0,0,0,0,0,0,0,0,0,0);
    exp(0,7,0,0,0,1,0,0,0,0,0);
    exp(0,0,0,0,0,0,1,0,1,0,0);
    exp(0,0,5,1,0,0,0,0,0,0,0);
    exp(1,0,0,0,0,0,0,0,0,0,0);
    @(posedge clk);
    #1;
    s = 1'b1;
    instr = 16'hE000;
    @(posedge clk);
    @(posedge clk);
    #1;
    s = 1'b0;

    // MVN R7,R1
    e_sh = 2'b00; e_op = 2'b11; e_imm = 16'hFFE1;
    issue(16'hB8E1, 1'b0);
    exp(0,0,0,0,0,0,0,0,0,0,0);
    exp(0,1,0,0,0,1,0,0,0,0,0);
    exp(0,0,0,0,0,0,1,0,0,0,0);
    exp(0,0,7,1,0,0,0,0,0,0,0);
    exp(1,0,0,0,0,0,0,0,0,0,0);

    // AND R4,R4,R4 sh=10
    e_sh = 2'b10; e_op = 2'b10; e_imm = 16'hFF94;
    issue(16'hB494, 1'b0);
    exp(0,0,0,0,0,0,0,0,0,0,0);
    exp(0,4,0,0,1,0,0,0,0,0,0);
    exp(0,4,0,0,0,1,0,0,0,0,0);
    exp(0,0,0,0,0,0,1,0,0,0,0);
    exp(0,0,4,1,0,0,0,0,0,0,0);
    exp(1,0,0,0,0,0,0,0,0,0,0);

    // illegal opcode 111
    e_sh = 2'b00; e_op = 2'b00; e_imm = 16'h0000;
    issue(16'hE000, 1'b0);
    exp(0,0,0,0,0,0,0,0,0,0,0);
    exp(1,0,0,0,0,0,0,0,0,0,1);
    repeat (4) @(negedge clk);
    chkb("err_sticky", err, 1'b1);
    chkb("w_after_illegal", w, 1'b1);

    // illegal 110/01
    e_sh = 2'b00; e_op = 2'b01; e_imm = 16'h0000;
    issue(16'hC800, 1'b0);
    exp(0,0,0,0,0,0,0,0,0,0,0);
    exp(1,0,0,0,0,0,0,0,0,0,1);

    // MOV R0,#0x7F clears err; s held into MOV R1,#0x80
    e_sh = 2'b00; e_op = 2'b10; e_imm = 16'h007F;
    issue(16'hD07F, 1'b1);
    exp(0,0,0,0,0,0,0,0,0,0,0);
    exp(0,0,0,1,0,0,0,0,0,1,0);
    exp(1,0,0,0,0,0,0,0,0,0,0);
    e_sh = 2'b00; e_op = 2'b10; e_imm = 16'hFF80;
    issue(16'hD180, 1'b0);
    exp(0,0,0,0,0,0,0,0,0,0,0);
    exp(0,0,1,1,0,0,0,0,0,1,0);
    exp(1,0,0,0,0,0,0,0,0,0,0);

    // reset while in S_GETB of an ADD
    e_sh = 2'b00; e_op = 2'b00; e_imm = 16'h0040;
    issue(16'hA140, 1'b0);
    exp(0,0,0,0,0,0,0,0,0,0,0);
    exp(0,1,0,0,1,0,0,0,0,0,0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chkb("getb_before_reset", loadb, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid", dut_snap(), rst_exp);
    sb.delete();
    wcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (write) wcnt++;
    end
    total++;
    if (wcnt != 0) begin
      bad++;
      $display("FAIL write_after_reset: got %0d pulses want 0", wcnt);
    end
    rst_n = 1'b1;

    // MOV R3,#0x85 after reset
    e_sh = 2'b00; e_op = 2'b10; e_imm = 16'hFF85;
    issue(16'hD385, 1'b0);
    exp(0,0,0,0,0,0,0,0,0,0,0);
    exp(0,0,3,1,0,0,0,0,0,1,0);
    exp(1,0,0,0,0,0,0,0,0,0,0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
